// File: rtl/fetch_stage.sv
// Instruction fetch stage. It holds the fetch PC and issues in-order requests
// to a variable-latency instruction memory, with at most two requests in flight.
// Returned instructions are buffered in a two-entry queue whose head drives the
// IF/ID outputs. A redirect discards the queue and any in-flight responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall_FD,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_IF,
  output logic [31:0] IDATA_IF,
  output logic [31:0] PC4_IF,
  output logic        valid_IF
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q,  resp_pc_d;
  logic [1:0]  inflight_q, inflight_d;
  logic [1:0]  drop_q,     drop_d;
  logic [1:0]  count_q,    count_d;
  logic [31:0] q_pc_q   [2];
  logic [31:0] q_pc_d   [2];
  logic [31:0] q_insn_q [2];
  logic [31:0] q_insn_d [2];

  logic        pop, grant, rsp, keep;
  logic [2:0]  credit;
  logic [1:0]  wr_idx;
  logic [31:0] target;

  // Handshake terms, issue credit and head-of-queue outputs
  always_comb begin
    valid_IF  = (count_q != 2'd0);
    pop       = valid_IF & ~stall_FD & ~redirect;
    // Slots already promised: queued entries plus outstanding requests,
    // less the entry leaving this cycle.
    credit    = {1'b0, inflight_q} + {1'b0, count_q} - {2'b00, pop};
    imem_req  = ~RST & ~redirect & (credit < 3'd2);
    imem_addr = fetch_pc_q;
    grant     = imem_req & imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp       = imem_rvalid & (inflight_q != 2'd0);
    keep      = rsp & (drop_q == 2'd0);
    wr_idx    = count_q - {1'b0, pop};
    target    = {redirect_pc[31:2], 2'b00};
    PC_IF     = valid_IF ? q_pc_q[0] : '0;
    PC4_IF    = valid_IF ? q_pc_q[0] + 32'd4 : '0;
    IDATA_IF  = valid_IF ? q_insn_q[0] : NOP_INSN;
  end

  // Next-state: PCs, credit counters and queue contents
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    count_d    = count_q;
    q_pc_d     = q_pc_q;
    q_insn_d   = q_insn_q;
    inflight_d = inflight_q + {1'b0, grant} - {1'b0, rsp};
    if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect) begin
      // Everything still outstanding belongs to the wrong path; the response
      // arriving this cycle is already consumed so it is not counted.
      count_d    = '0;
      fetch_pc_d = target;
      resp_pc_d  = target;
      drop_d     = inflight_q - {1'b0, rsp};
    end else begin
      if (rsp && (drop_q != 2'd0)) drop_d = drop_q - 2'd1;
      // Head sits at index 0; a pop shifts the second entry forward and a
      // push lands behind whatever remains after the pop.
      if (pop) begin
        q_pc_d[0]   = q_pc_q[1];
        q_insn_d[0] = q_insn_q[1];
      end
      if (keep) begin
        q_pc_d[wr_idx[0]]   = resp_pc_q;
        q_insn_d[wr_idx[0]] = imem_rdata;
        resp_pc_d           = resp_pc_q + 32'd4;
      end
      count_d = count_q + {1'b0, keep} - {1'b0, pop};
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      q_pc_q     <= '{default: '0};
      q_insn_q   <= '{default: '0};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      q_pc_q     <= q_pc_d;
      q_insn_q   <= q_insn_d;
    end
  end

endmodule
